// File: rtl/part1_register_pkg.sv
// ---------------------------------------------------------------------------
// part1_register_pkg
// Shared FunSel encodings for part1_register and its sibling blocks
// (register file, address register file).
//   FS_DEC  : decrement, modulo 2^n
//   FS_INC  : increment, modulo 2^n
//   FS_LOAD : load data_in
//   FS_CLR  : clear to zero
// ---------------------------------------------------------------------------
package part1_register_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

endpackage : part1_register_pkg

// File: rtl/part1_register_next_value.sv
// ---------------------------------------------------------------------------
// part1_next_value
// Purely combinational next-value function for part1_register.
// Ports:
//   cur_val  [n-1:0] in  : current register contents
//   FunSel   [1:0]   in  : function select (see part1_register_pkg)
//   data_in  [n-1:0] in  : load operand, used only for FS_LOAD
//   next_val [n-1:0] out : value to capture when the register is enabled
// ---------------------------------------------------------------------------
module part1_next_value
  import part1_register_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0] cur_val,
  input  logic [1:0]   FunSel,
  input  logic [n-1:0] data_in,
  output logic [n-1:0] next_val
);

  always_comb begin
    next_val = '0;
    case (FunSel)
      FS_DEC:  next_val = cur_val - n'(1);
      FS_INC:  next_val = cur_val + n'(1);
      FS_LOAD: next_val = data_in;
      FS_CLR:  next_val = '0;
      // Illegal X/Z select resolves to zero so the flop never captures X
      // from a defined pattern.
      default: next_val = '0;
    endcase
  end

endmodule : part1_next_value

// File: rtl/part1_register.sv
// ---------------------------------------------------------------------------
// part1_register
// n-bit register with decrement / increment / load / clear, qualified by
// enable and overridden by a synchronous active-high reset.
// Ports:
//   clk      in        : clock, rising edge
//   rst      in        : synchronous active-high reset to zero
//   FunSel   in  [1:0] : 00 dec, 01 inc, 10 load, 11 clear
//   data_in  in  [n-1:0] : load operand
//   enable   in        : per-cycle operation enable
//   data_out out [n-1:0] : register contents, straight from the flop
// ---------------------------------------------------------------------------
module part1_register
  import part1_register_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   FunSel,
  input  logic [n-1:0] data_in,
  input  logic         enable,
  output logic [n-1:0] data_out
);

  logic [n-1:0] data_q;
  logic [n-1:0] data_d;
  logic [n-1:0] next_val;

  part1_next_value #(
    .n (n)
  ) u_next_value (
    .cur_val  (data_q),
    .FunSel   (FunSel),
    .data_in  (data_in),
    .next_val (next_val)
  );

  always_comb begin
    data_d = data_q;
    if (enable) begin
      data_d = next_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule : part1_register

// File: tb/tb_part1_register.sv
// ---------------------------------------------------------------------------
// tb_part1_register
// Directed and randomized checks of part1_register with n = 4.
// ---------------------------------------------------------------------------
module tb_part1_register;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   FunSel;
  logic [N-1:0] data_in;
  logic         enable;
  logic [N-1:0] data_out;

  int n_checks;
  int n_fail;

  part1_register #(
    .n (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .FunSel   (FunSel),
    .data_in  (data_in),
    .enable   (enable),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply current inputs on the next rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic en, input logic [1:0] fs,
                       input logic [N-1:0] din);
    rst     = r;
    enable  = en;
    FunSel  = fs;
    data_in = din;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 2'b10, 4'b1010);
    step();
    n_checks++;
    if (data_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset: got %b expected %b", data_out, 4'b0000);
    end
  endtask

  task automatic test_load_count();
    logic [N-1:0] exp_seq [4];
    logic [1:0]   fs_seq  [4];
    exp_seq = '{4'b0010, 4'b0011, 4'b0010, 4'b0001};
    fs_seq  = '{2'b10, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, fs_seq[i], 4'b0010);
      step();
      n_checks++;
      if (data_out !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL load_count[%0d]: got %b expected %b", i, data_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 2'b10, 4'b0010);
    step();
    n_checks++;
    if (data_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold_load: got %b expected %b", data_out, 4'b0010);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 2'(i), 4'b1101);
      step();
      n_checks++;
      if (data_out !== 4'b0010) begin
        n_fail++;
        $display("FAIL hold[fs=%0d]: got %b expected %b", i, data_out, 4'b0010);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 2'b11, 4'b0000);
    step();
    drive(1'b0, 1'b1, 2'b00, 4'b0000);
    step();
    n_checks++;
    if (data_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL wrap_dec: got %b expected %b", data_out, 4'b1111);
    end
    drive(1'b0, 1'b1, 2'b01, 4'b0000);
    step();
    n_checks++;
    if (data_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_inc: got %b expected %b", data_out, 4'b0000);
    end
  endtask

  task automatic test_clear();
    drive(1'b0, 1'b1, 2'b10, 4'b0110);
    step();
    n_checks++;
    if (data_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL clear_load: got %b expected %b", data_out, 4'b0110);
    end
    drive(1'b0, 1'b1, 2'b11, 4'b0110);
    step();
    n_checks++;
    if (data_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL clear: got %b expected %b", data_out, 4'b0000);
    end
  endtask

  task automatic test_rst_mid();
    // From 0000: inc, inc, inc with rst, inc
    logic         r_seq   [4];
    logic [N-1:0] exp_seq [4];
    r_seq   = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_seq = '{4'b0001, 4'b0010, 4'b0000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive(r_seq[i], 1'b1, 2'b01, 4'b1001);
      step();
      n_checks++;
      if (data_out !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL rst_mid[%0d]: got %b expected %b", i, data_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] model;
    logic         r;
    logic         en;
    logic [1:0]   fs;
    logic [N-1:0] din;
    int           rand_fail;
    rand_fail = 0;
    drive(1'b1, 1'b0, 2'b00, 4'b0000);
    step();
    model = 4'b0000;
    for (int i = 0; i < 1000; i++) begin
      r   = ($urandom_range(0, 15) == 0);
      en  = 1'($urandom_range(0, 1));
      fs  = 2'($urandom_range(0, 3));
      din = 4'($urandom_range(0, 15));
      drive(r, en, fs, din);
      if (r)
        model = 4'b0000;
      else if (en) begin
        case (fs)
          2'b00: model = model - 4'd1;
          2'b01: model = model + 4'd1;
          2'b10: model = din;
          default: model = 4'b0000;
        endcase
      end
      step();
      n_checks++;
      if (data_out !== model) begin
        n_fail++;
        rand_fail++;
        if (rand_fail <= 10)
          $display("FAIL random[%0d] rst=%b en=%b fs=%b din=%b: got %b expected %b",
                   i, r, en, fs, din, data_out, model);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1'b0, 1'b0, 2'b00, 4'b0000);
    #2;
    test_reset();
    test_load_count();
    test_hold();
    test_wrap();
    test_clear();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_part1_register
